// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - acquisition command handshake bundle
interface frame_sequencer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_frame_count;
    logic [15:0] cfg_integration_time;
    logic [11:0] cfg_row_start;
    logic [11:0] cfg_row_end;
    logic [11:0] cfg_col_start;
    logic [11:0] cfg_col_end;

    modport master (
        output cfg_valid, cfg_frame_count, cfg_integration_time,
               cfg_row_start, cfg_row_end, cfg_col_start, cfg_col_end,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_frame_count, cfg_integration_time,
               cfg_row_start, cfg_row_end, cfg_col_start, cfg_col_end,
        output cfg_ready
    );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - multi-frame acquisition sequencer for the panel timing generator
module frame_sequencer #(
    parameter int GAP_CYCLES    = 4,
    parameter int BUSY_TIMEOUT  = 16,
    parameter int FRAME_TIMEOUT = 200000
) (
    input  logic              clk,
    input  logic              rst,
    frame_sequencer_if.slave  cfg,
    input  logic              abort,
    output logic              tg_frame_start,
    output logic              tg_frame_reset,
    output logic [15:0]       tg_integration_time,
    output logic [11:0]       tg_row_start,
    output logic [11:0]       tg_row_end,
    output logic [11:0]       tg_col_start,
    output logic [11:0]       tg_col_end,
    input  logic              tg_frame_busy,
    input  logic              tg_frame_complete,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [15:0]       frames_done,
    output logic [1:0]        err_code
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHECK     = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;
    localparam logic [2:0] FAULT     = 3'd6;

    // Limits are one less than the timeouts because the watchdog is 0 on the first cycle of a state.
    localparam logic [17:0] WD_MAX     = '1;
    localparam logic [17:0] BUSY_LIM   = 18'(BUSY_TIMEOUT - 1);
    localparam logic [17:0] FRAME_LIM  = 18'(FRAME_TIMEOUT - 1);
    localparam logic [17:0] GAP_LIM    = 18'(GAP_CYCLES - 1);

    logic [2:0]  state, next_state;
    logic [17:0] wd;
    logic [15:0] frame_count;
    logic        busy_q;
    logic        bad_cfg, abort_hit, frame_end, last_frame;

    always_comb begin
        bad_cfg    = (frame_count == 16'd0) || (tg_integration_time == 16'd0) ||
                     (tg_row_end < tg_row_start) || (tg_col_end < tg_col_start);
        abort_hit  = abort && (state != IDLE) && (state != CHECK);
        frame_end  = (state == WAIT_DONE) && !abort_hit &&
                     (tg_frame_complete || (busy_q && !tg_frame_busy));
        last_frame = (frames_done + 16'd1) == frame_count;

        next_state = state;
        case (state)
            IDLE:      if (cfg.cfg_valid) next_state = CHECK;
            CHECK:     next_state = bad_cfg ? IDLE : START;
            START:     next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tg_frame_busy)         next_state = WAIT_DONE;
                else if (wd >= BUSY_LIM)   next_state = FAULT;
            end
            WAIT_DONE: begin
                if (frame_end)             next_state = last_frame ? IDLE : GAP;
                else if (wd >= FRAME_LIM)  next_state = FAULT;
            end
            GAP:       if (wd >= GAP_LIM) next_state = START;
            FAULT:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (abort_hit) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            wd                  <= '0;
            busy_q              <= 1'b0;
            frame_count         <= '0;
            cfg.cfg_ready       <= 1'b1;
            tg_frame_start      <= 1'b0;
            tg_frame_reset      <= 1'b0;
            tg_integration_time <= '0;
            tg_row_start        <= '0;
            tg_row_end          <= '0;
            tg_col_start        <= '0;
            tg_col_end          <= '0;
            seq_busy            <= 1'b0;
            seq_done            <= 1'b0;
            frames_done         <= '0;
            err_code            <= 2'd0;
        end else begin
            state          <= next_state;
            wd             <= (next_state != state) ? '0 :
                              ((wd == WD_MAX) ? wd : wd + 18'd1);
            busy_q         <= tg_frame_busy;
            cfg.cfg_ready  <= (next_state == IDLE);
            seq_busy       <= (next_state != IDLE);
            tg_frame_start <= (next_state == START);
            tg_frame_reset <= abort_hit || (next_state == FAULT);
            seq_done       <= frame_end && last_frame;

            if (state == IDLE && cfg.cfg_valid) begin
                frame_count         <= cfg.cfg_frame_count;
                tg_integration_time <= cfg.cfg_integration_time;
                tg_row_start        <= cfg.cfg_row_start;
                tg_row_end          <= cfg.cfg_row_end;
                tg_col_start        <= cfg.cfg_col_start;
                tg_col_end          <= cfg.cfg_col_end;
                frames_done         <= '0;
                err_code            <= 2'd0;
            end
            if (state == CHECK && bad_cfg) err_code <= 2'd1;
            if (next_state == FAULT)       err_code <= 2'd2;
            if (abort_hit)                 err_code <= 2'd3;
            if (frame_end)                 frames_done <= frames_done + 16'd1;
        end
    end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Host-side initiator for the panel timing generator. Accepts a multi-frame acquisition command over a valid/ready handshake and validates the ROI and integration settings. It then drives the generator's frame_start/frame_reset/config inputs and tracks its frame_busy/frame_complete responses frame by frame, with watchdog timeouts and abort. It sits between the register/host interface and the timing generator instance.

## Interface
- GAP_CYCLES, 4: idle cycles between the end of one frame and the next start pulse (≥1)
- BUSY_TIMEOUT, 16: max cycles from start pulse to frame_busy high
- FRAME_TIMEOUT, 200000: max cycles from frame_busy high to frame end
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command accepted this cycle when both high
- cfg_frame_count  in  16  frames to acquire
- cfg_integration_time  in  16  passed to generator
- cfg_row_start, cfg_row_end, cfg_col_start, cfg_col_end  in  12 each  ROI window
- abort  in  1  level; terminates the sequence
- tg_frame_start  out  1  single-cycle start pulse to generator
- tg_frame_reset  out  1  single-cycle reset pulse to generator
- tg_integration_time  out  16  registered config
- tg_row_start, tg_row_end, tg_col_start, tg_col_end  out  12 each  registered ROI
- tg_frame_busy  in  1  generator busy
- tg_frame_complete  in  1  generator completion pulse
- seq_busy  out  1  sequence in progress
- seq_done  out  1  one-cycle pulse on successful completion of all frames
- frames_done  out  16  frames completed in the current or last sequence
- err_code  out  2  0 none, 1 bad config, 2 timeout, 3 aborted; holds until next accepted command

## Operation
- States: IDLE, CHECK, START, WAIT_BUSY, WAIT_DONE, GAP, FAULT.
- IDLE: cfg_ready=1. On cfg_valid, latch all cfg_* into tg_* registers, clear frames_done and err_code, go to CHECK.
- CHECK (1 cycle): reject if frame_count==0, integration_time==0, row_end<row_start, or col_end<col_start. Comparisons are unsigned. Reject sets err_code=1 and returns to IDLE with no tg_* pulse and no seq_done. Otherwise go to START.
- START: assert tg_frame_start for exactly one cycle, clear the watchdog, go to WAIT_BUSY.
- WAIT_BUSY: on tg_frame_busy=1 go to WAIT_DONE. Watchdog reaching BUSY_TIMEOUT goes to FAULT.
- WAIT_DONE: the frame ends on tg_frame_complete=1 or a busy falling edge (busy was 1 last cycle, 0 now). Both in the same cycle count as one frame. On frame end, frames_done+1; if it equals cfg_frame_count, pulse seq_done and go to IDLE, else go to GAP. Watchdog reaching FRAME_TIMEOUT goes to FAULT.
- GAP: count GAP_CYCLES, then go to START.
- FAULT (1 cycle): tg_frame_reset=1, err_code=2, go to IDLE.
- abort=1 in any state other than IDLE/CHECK: tg_frame_reset pulse next cycle, err_code=3, go to IDLE, no seq_done. Abort takes priority over frame end and timeout in the same cycle; frames_done is not incremented. Abort in IDLE is ignored.
- The watchdog is 18-bit and saturates; it resets on every state entry.
- seq_busy=1 in every state except IDLE.
- frames_done does not wrap; the maximum is 65535.

## Timing
- Reset: state IDLE; cfg_ready=1; tg_frame_start=0; tg_frame_reset=0; seq_busy=0; seq_done=0; frames_done=0; err_code=0; all tg_* config registers 0.
- All outputs are registered.
- tg_frame_start goes high 2 cycles after the cfg handshake cycle (CHECK, then START).
- Frame end to next tg_frame_start: GAP_CYCLES+1 cycles.
- seq_done asserts the cycle after the final frame-end detection.
- tg_* config registers are stable from acceptance until the next accepted command.
- cfg_ready=0 whenever seq_busy=1.
- Reset mid-sequence: immediate return to IDLE with reset values. No tg_frame_reset pulse is issued; the generator shares rst.

## Test plan
- Nominal: frame_count=3, integration_time=1, ROI 0..2/0..2; generator model busy for 50 cycles → exactly 3 start pulses, each gap GAP_CYCLES+1 cycles, frames_done=3, one seq_done pulse, err_code=0.
- Bad config: row_start=5, row_end=2 → err_code=1, no tg_frame_start, seq_busy low 2 cycles after handshake; repeat with frame_count=0 → same result.
- Busy timeout: model never raises busy → tg_frame_reset pulse BUSY_TIMEOUT+1 cycles after the start pulse, err_code=2, frames_done=0.
- Frame timeout (FRAME_TIMEOUT=1000 override): busy stuck high → FAULT, tg_frame_reset pulse, err_code=2.
- Abort: abort asserted during frame 2 of 4 → tg_frame_reset pulse, err_code=3, frames_done=1, no seq_done; abort and frame end in the same cycle → frames_done not incremented.
- Completion edge cases: complete pulse and busy fall in the same cycle → counted once; frame_count=1 → seq_done without entering GAP; new command in the cycle after seq_done is accepted and clears err_code and frames_done.
